write_master_arbiter: RTL and testbench

- Shares the single pipelined Avalon write master among NUM_REQ result-writing engines (e.g. parallel classifier stages).
- Grants one requester at a time, round-robin, with bounded bursts.
- Relocates each requester's address into its own region and registers the selected beat onto the write master's request/address/data inputs.
- Aggregates per-requester finish pulses into one level finish for the write master / control slave.

---
 rtl/face_det_bus_pkg.sv | 24 ++
 rtl/write_master_arbiter_rr_pick.sv | 38 +++
 rtl/write_master_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_write_master_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/face_det_bus_pkg.sv
// Shared bus definitions for the face-detect result-writing path:
// bus widths, arbiter state encoding and address relocation / counter helpers.
package face_det_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Arbiter state encoding (kept as plain constants for legacy compatibility)
    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    // Place a requester's word offset inside its own region; carry out of bit 31 is dropped.
    function automatic logic [ADDR_W-1:0] relocate(input logic [ADDR_W-1:0] addr,
                                                   input logic [7:0]        idx,
                                                   input int                shift);
        return addr + (ADDR_W'(idx) << shift);
    endfunction

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/write_master_arbiter_rr_pick.sv
// Round-robin pick: first set request bit searching upward from ptr, wrapping at N.
module write_master_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest set bit after ptr is the last writer.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        sum_s  = '0;
        cand_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(N)) begin
                sum_s = sum_s - (IDX_W+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (req[cand_s]) begin
                valid = 1'b1;
                idx   = cand_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/write_master_arbiter.sv
// Shares one pipelined Avalon write master among NUM_REQ result writers.
// Round-robin grants with bounded bursts, per-requester address relocation,
// registered output beat and an aggregated finish level.
// Optional statistics counters are built when WRITE_MASTER_ARBITER_STATS_EN is defined.
module write_master_arbiter
    import face_det_bus_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int IDX_W        = 2,
    parameter int MAX_BURST    = 16,
    parameter int REGION_SHIFT = 20
) (
    input  logic                      iClk,
    input  logic                      iReset_n,
    input  logic                      iStart,
    input  logic [NUM_REQ-1:0]        iReq_write,
    input  logic [NUM_REQ*ADDR_W-1:0] iReq_address,
    input  logic [NUM_REQ*DATA_W-1:0] iReq_data,
    input  logic [NUM_REQ-1:0]        iReq_finish,
    output logic [NUM_REQ-1:0]        oReq_wait,
    input  logic                      iWM_wait_request,
    output logic                      oWM_write_request,
    output logic [ADDR_W-1:0]         oWM_write_address,
    output logic [DATA_W-1:0]         oWM_write_data,
    output logic                      oWM_finish,
    output logic [IDX_W-1:0]          oGrant_idx
`ifdef WRITE_MASTER_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     oBeat_count,
    output logic [31:0]               oStall_cycles
`endif
);

    localparam int              BEAT_W    = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    logic [0:0]         state_r;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [BEAT_W-1:0]  beat_cnt_r;
    logic [NUM_REQ-1:0] done_mask_r;

    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               owner_write_s;
    logic               accepted_s;
    logic [IDX_W:0]     ptr_inc_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_data_s;

    write_master_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (iReq_write),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    assign oGrant_idx    = owner_r;
    assign owner_write_s = iReq_write[owner_r];
    assign accepted_s    = (state_r == ARB_GRANT) && owner_write_s && !iWM_wait_request;

    // Next round-robin pointer is the slot after the releasing owner, wrapping at NUM_REQ.
    always_comb begin
        ptr_inc_s = {1'b0, owner_r} + (IDX_W+1)'(1);
        if (ptr_inc_s >= (IDX_W+1)'(NUM_REQ)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = ptr_inc_s[IDX_W-1:0];
        end
    end

    // Only the owner sees wait low, and only while the write master is not stalling.
    always_comb begin
        oReq_wait = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            oReq_wait[i] = !((state_r == ARB_GRANT) && (owner_r == IDX_W'(i)) && !iWM_wait_request);
        end
    end

    // Select the owner's address and data lanes from the packed buses.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_r == IDX_W'(i)) begin
                sel_addr_s = iReq_address[i*ADDR_W +: ADDR_W];
                sel_data_s = iReq_data[i*DATA_W +: DATA_W];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Arbitration FSM: grant, count accepted beats, release on idle owner or full burst.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_r    <= ARB_IDLE;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        owner_r    <= pick_idx_s;
                        beat_cnt_r <= '0;
                        state_r    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!owner_write_s || (accepted_s && (beat_cnt_r == LAST_BEAT))) begin
                        state_r    <= ARB_IDLE;
                        rr_ptr_r   <= next_ptr_s;
                        beat_cnt_r <= '0;
                    end else if (accepted_s) begin
                        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
            // A new job restarts fairness and the burst count, but never revokes a grant.
            if (iStart) begin
                rr_ptr_r   <= '0;
                beat_cnt_r <= '0;
            end
        end
    end

    // Output register: one write strobe per accepted beat; address/data hold otherwise.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            oWM_write_request <= 1'b0;
            oWM_write_address <= '0;
            oWM_write_data    <= '0;
        end else begin
            oWM_write_request <= accepted_s;
            if (accepted_s) begin
                oWM_write_address <= relocate(sel_addr_s, 8'(owner_r), REGION_SHIFT);
                oWM_write_data    <= sel_data_s;
            end
        end
    end

    // Finish aggregation: sticky per-requester flags, level raised only once the output has drained.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            done_mask_r <= '0;
            oWM_finish  <= 1'b0;
        end else if (iStart) begin
            done_mask_r <= '0;
            oWM_finish  <= 1'b0;
        end else begin
            done_mask_r <= done_mask_r | iReq_finish;
            oWM_finish  <= oWM_finish | ((&done_mask_r) && !oWM_write_request && !accepted_s);
        end
    end

`ifdef WRITE_MASTER_ARBITER_STATS_EN
    // Saturating per-requester beat counters and write-master stall counter.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            oBeat_count   <= '0;
            oStall_cycles <= '0;
        end else if (iStart) begin
            oBeat_count   <= '0;
            oStall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accepted_s && (owner_r == IDX_W'(i))) begin
                    oBeat_count[i*32 +: 32] <= sat_inc32(oBeat_count[i*32 +: 32]);
                end
            end
            if ((state_r == ARB_GRANT) && owner_write_s && iWM_wait_request) begin
                oStall_cycles <= sat_inc32(oStall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_write_master_arbiter.sv
// Directed self-checking bench for write_master_arbiter (default build).
module tb_write_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    logic                 iClk = 1'b0;
    logic                 iReset_n;
    logic                 iStart;
    logic [NUM_REQ-1:0]   iReq_write;
    logic [NUM_REQ*32-1:0] iReq_address;
    logic [NUM_REQ*32-1:0] iReq_data;
    logic [NUM_REQ-1:0]   iReq_finish;
    logic [NUM_REQ-1:0]   oReq_wait;
    logic                 iWM_wait_request;
    logic                 oWM_write_request;
    logic [31:0]          oWM_write_address;
    logic [31:0]          oWM_write_data;
    logic                 oWM_finish;
    logic [IDX_W-1:0]     oGrant_idx;

    int n_total = 0;
    int n_pass  = 0;

    // Requester model: each requester presents abase+cnt / dbase+cnt and advances on accept.
    logic [31:0] cnt   [NUM_REQ];
    logic [31:0] abase [NUM_REQ];
    logic [31:0] dbase [NUM_REQ];
    logic        acc   [NUM_REQ];

    write_master_arbiter #(
        .NUM_REQ(4), .IDX_W(2), .MAX_BURST(16), .REGION_SHIFT(20)
    ) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart),
        .iReq_write(iReq_write), .iReq_address(iReq_address), .iReq_data(iReq_data),
        .iReq_finish(iReq_finish), .oReq_wait(oReq_wait),
        .iWM_wait_request(iWM_wait_request), .oWM_write_request(oWM_write_request),
        .oWM_write_address(oWM_write_address), .oWM_write_data(oWM_write_data),
        .oWM_finish(oWM_finish), .oGrant_idx(oGrant_idx)
    );

    always #5 iClk = ~iClk;

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i]   = 32'd0;
            acc[i]   = 1'b0;
            abase[i] = 32'd0;
            dbase[i] = 32'hD000_0000 | (32'(i) << 8);
        end
    endtask

    // Advance to the next falling edge, end one-cycle pulses, update the requester lanes.
    task automatic drive_cycle();
        @(negedge iClk);
        iStart      = 1'b0;
        iReq_finish = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) cnt[i] = cnt[i] + 32'd1;
            iReq_address[i*32 +: 32] = abase[i] + cnt[i];
            iReq_data[i*32 +: 32]    = dbase[i] + cnt[i];
        end
    endtask

    // Let combinational wait settle and record which beats the next rising edge accepts.
    task automatic settle();
        #1;
        for (int i = 0; i < NUM_REQ; i++) acc[i] = iReq_write[i] & ~oReq_wait[i];
    endtask

    task automatic test_reset();
        iReset_n = 1'b0; iStart = 1'b0; iReq_write = '0; iReq_finish = '0;
        iWM_wait_request = 1'b0; iReq_address = '0; iReq_data = '0;
        model_reset();
        repeat (3) drive_cycle();
        settle();
        n_total++; if (oWM_write_request !== 1'b0) $display("FAIL reset_req: got %0b want 0", oWM_write_request); else n_pass++;
        n_total++; if (oWM_write_address !== 32'd0) $display("FAIL reset_addr: got %h want 0", oWM_write_address); else n_pass++;
        n_total++; if (oWM_write_data !== 32'd0) $display("FAIL reset_data: got %h want 0", oWM_write_data); else n_pass++;
        n_total++; if (oWM_finish !== 1'b0) $display("FAIL reset_finish: got %0b want 0", oWM_finish); else n_pass++;
        n_total++; if (oGrant_idx !== 2'd0) $display("FAIL reset_grant: got %0d want 0", oGrant_idx); else n_pass++;
        n_total++; if (oReq_wait !== 4'hF) $display("FAIL reset_wait: got %b want 1111", oReq_wait); else n_pass++;
        drive_cycle();
        iReset_n = 1'b1;
        settle();
    endtask

    task automatic test_single_req2();
        model_reset();
        dbase[2] = 32'h0000_00A0;
        drive_cycle(); iReq_write = 4'b0100; settle();
        drive_cycle(); settle();
        n_total++; if (oWM_write_request !== 1'b0) $display("FAIL single_first_req: got %0b want 0", oWM_write_request); else n_pass++;
        n_total++; if (oReq_wait !== 4'b1011) $display("FAIL single_wait: got %b want 1011", oReq_wait); else n_pass++;
        n_total++; if (oGrant_idx !== 2'd2) $display("FAIL single_grant: got %0d want 2", oGrant_idx); else n_pass++;
        for (int b = 0; b < 4; b++) begin
            drive_cycle();
            if (b == 3) iReq_write = '0;
            settle();
            n_total++; if (oWM_write_request !== 1'b1) $display("FAIL single_req b%0d: got %0b want 1", b, oWM_write_request); else n_pass++;
            n_total++; if (oWM_write_address !== 32'h0020_0000 + 32'(b)) $display("FAIL single_addr b%0d: got %h want %h", b, oWM_write_address, 32'h0020_0000 + 32'(b)); else n_pass++;
            n_total++; if (oWM_write_data !== 32'h0000_00A0 + 32'(b)) $display("FAIL single_data b%0d: got %h want %h", b, oWM_write_data, 32'h0000_00A0 + 32'(b)); else n_pass++;
        end
        drive_cycle(); settle();
        n_total++; if (oWM_write_request !== 1'b0) $display("FAIL single_tail_req: got %0b want 0", oWM_write_request); else n_pass++;
        n_total++; if (oWM_write_address !== 32'h0020_0003) $display("FAIL single_hold_addr: got %h want 00200003", oWM_write_address); else n_pass++;
        n_total++; if (oReq_wait !== 4'hF) $display("FAIL single_idle_wait: got %b want 1111", oReq_wait); else n_pass++;
        drive_cycle(); settle();
    endtask

    task automatic test_rotation();
        logic        exp_v;
        logic [31:0] exp_a, exp_d, bc;
        int          j, g, b, own;
        model_reset();
        drive_cycle(); iStart = 1'b1; settle();
        drive_cycle(); iReq_write = 4'hF; settle();
        for (int k = 1; k <= 86; k++) begin
            drive_cycle();
            if (k == 86) iReq_write = '0;
            settle();
            exp_v = 1'b0; exp_a = 32'd0; exp_d = 32'd0; own = 0; b = 0;
            if (k >= 2) begin
                j = k - 2; g = j / 17; b = j % 17; own = g % 4;
                if (b < 16) begin
                    bc    = 32'(b) + ((g == 4) ? 32'd16 : 32'd0);
                    exp_v = 1'b1;
                    exp_a = (32'(own) << 20) + bc;
                    exp_d = dbase[own] + bc;
                end
            end
            n_total++; if (oWM_write_request !== exp_v) $display("FAIL rot_req k%0d: got %0b want %0b", k, oWM_write_request, exp_v); else n_pass++;
            if (exp_v) begin
                n_total++; if (oWM_write_address !== exp_a) $display("FAIL rot_addr k%0d: got %h want %h", k, oWM_write_address, exp_a); else n_pass++;
                n_total++; if (oWM_write_data !== exp_d) $display("FAIL rot_data k%0d: got %h want %h", k, oWM_write_data, exp_d); else n_pass++;
                if (b == 0) begin
                    n_total++; if (oGrant_idx !== IDX_W'(own)) $display("FAIL rot_grant k%0d: got %0d want %0d", k, oGrant_idx, own); else n_pass++;
                end
            end
        end
        drive_cycle(); settle();
        drive_cycle(); settle();
    endtask

    task automatic test_backpressure();
        logic        exp_v;
        logic [31:0] bc;
        model_reset();
        drive_cycle(); iReq_write = 4'b0010; settle();
        for (int k = 1; k <= 24; k++) begin
            drive_cycle();
            iWM_wait_request = (k >= 4 && k <= 8) ? 1'b1 : 1'b0;
            if (k == 24) iReq_write = '0;
            settle();
            exp_v = 1'b0; bc = 32'd0;
            if (k >= 2 && k <= 4)  begin exp_v = 1'b1; bc = 32'(k - 2); end
            if (k >= 10 && k <= 22) begin exp_v = 1'b1; bc = 32'(k - 7); end
            if (k == 24) begin exp_v = 1'b1; bc = 32'd16; end
            n_total++; if (oWM_write_request !== exp_v) $display("FAIL bp_req k%0d: got %0b want %0b", k, oWM_write_request, exp_v); else n_pass++;
            if (exp_v) begin
                n_total++; if (oWM_write_address !== (32'h0010_0000 + bc)) $display("FAIL bp_addr k%0d: got %h want %h", k, oWM_write_address, 32'h0010_0000 + bc); else n_pass++;
                n_total++; if (oWM_write_data !== (dbase[1] + bc)) $display("FAIL bp_data k%0d: got %h want %h", k, oWM_write_data, dbase[1] + bc); else n_pass++;
            end
            if (k >= 4 && k <= 8) begin
                n_total++; if (oReq_wait[1] !== 1'b1) $display("FAIL bp_wait k%0d: got %0b want 1", k, oReq_wait[1]); else n_pass++;
            end
            if (k == 9) begin
                n_total++; if (oReq_wait[1] !== 1'b0) $display("FAIL bp_resume_wait: got %0b want 0", oReq_wait[1]); else n_pass++;
            end
            n_total++; if (oGrant_idx !== 2'd1) $display("FAIL bp_grant k%0d: got %0d want 1", k, oGrant_idx); else n_pass++;
        end
        drive_cycle(); settle();
        drive_cycle(); settle();
    endtask

    task automatic test_drop();
        model_reset();
        drive_cycle(); iStart = 1'b1; settle();
        drive_cycle(); iReq_write = 4'b0101; settle();
        drive_cycle(); settle();
        n_total++; if (oGrant_idx !== 2'd0) $display("FAIL drop_grant0: got %0d want 0", oGrant_idx); else n_pass++;
        n_total++; if (oReq_wait !== 4'b1110) $display("FAIL drop_wait0: got %b want 1110", oReq_wait); else n_pass++;
        for (int b = 0; b < 3; b++) begin
            drive_cycle();
            if (b == 2) iReq_write = 4'b0100;
            settle();
            n_total++; if (oWM_write_address !== 32'(b) || oWM_write_request !== 1'b1) $display("FAIL drop_beat b%0d: got req %0b addr %h want req 1 addr %h", b, oWM_write_request, oWM_write_address, 32'(b)); else n_pass++;
        end
        drive_cycle(); iReq_write = 4'b0101; settle();
        n_total++; if (oReq_wait !== 4'hF || oWM_write_request !== 1'b0) $display("FAIL drop_release: got wait %b req %0b want wait 1111 req 0", oReq_wait, oWM_write_request); else n_pass++;
        drive_cycle(); settle();
        n_total++; if (oGrant_idx !== 2'd2) $display("FAIL drop_next_grant: got %0d want 2", oGrant_idx); else n_pass++;
        n_total++; if (oReq_wait !== 4'b1011 || oWM_write_request !== 1'b0) $display("FAIL drop_bubble: got wait %b req %0b want wait 1011 req 0", oReq_wait, oWM_write_request); else n_pass++;
        drive_cycle(); iReq_write = '0; settle();
        n_total++; if (oWM_write_request !== 1'b1 || oWM_write_address !== 32'h0020_0000) $display("FAIL drop_req2_beat: got req %0b addr %h want req 1 addr 00200000", oWM_write_request, oWM_write_address); else n_pass++;
        drive_cycle(); settle();
        drive_cycle(); settle();
    endtask

    task automatic test_finish();
        model_reset();
        drive_cycle(); iStart = 1'b1; settle();
        drive_cycle(); iReq_finish = 4'b0001; settle();
        drive_cycle(); iReq_finish = 4'b0010; settle();
        drive_cycle(); iReq_finish = 4'b0100; settle();
        for (int k = 0; k < 3; k++) begin
            drive_cycle(); settle();
            n_total++; if (oWM_finish !== 1'b0) $display("FAIL fin_partial c%0d: got %0b want 0", k, oWM_finish); else n_pass++;
        end
        drive_cycle(); iReq_write = 4'b1000; settle();
        drive_cycle(); iReq_finish = 4'b1000; settle();
        n_total++; if (oWM_finish !== 1'b0) $display("FAIL fin_grant_cycle: got %0b want 0", oWM_finish); else n_pass++;
        drive_cycle(); iReq_write = '0; settle();
        n_total++; if (oWM_write_request !== 1'b1 || oWM_finish !== 1'b0) $display("FAIL fin_beat_in_flight: got req %0b finish %0b want req 1 finish 0", oWM_write_request, oWM_finish); else n_pass++;
        drive_cycle(); settle();
        n_total++; if (oWM_finish !== 1'b0) $display("FAIL fin_draining: got %0b want 0", oWM_finish); else n_pass++;
        drive_cycle(); settle();
        n_total++; if (oWM_finish !== 1'b1) $display("FAIL fin_rise: got %0b want 1", oWM_finish); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(); settle();
            n_total++; if (oWM_finish !== 1'b1) $display("FAIL fin_sticky c%0d: got %0b want 1", k, oWM_finish); else n_pass++;
        end
        drive_cycle(); iStart = 1'b1; iReq_finish = 4'b0010; settle();
        drive_cycle(); settle();
        n_total++; if (oWM_finish !== 1'b0) $display("FAIL fin_start_clear: got %0b want 0", oWM_finish); else n_pass++;
        drive_cycle(); iReq_finish = 4'b1101; settle();
        for (int k = 0; k < 3; k++) begin
            drive_cycle(); settle();
            n_total++; if (oWM_finish !== 1'b0) $display("FAIL fin_start_wins c%0d: got %0b want 0", k, oWM_finish); else n_pass++;
        end
        drive_cycle(); iReq_finish = 4'b0010; settle();
        drive_cycle(); settle();
        n_total++; if (oWM_finish !== 1'b0) $display("FAIL fin_last_early: got %0b want 0", oWM_finish); else n_pass++;
        drive_cycle(); settle();
        n_total++; if (oWM_finish !== 1'b1) $display("FAIL fin_last_rise: got %0b want 1", oWM_finish); else n_pass++;
    endtask

    task automatic test_wrap();
        model_reset();
        abase[3] = 32'hFFFF_FFFF;
        drive_cycle(); iReq_write = 4'b1000; settle();
        drive_cycle(); settle();
        drive_cycle(); iReq_write = '0; settle();
        n_total++; if (oWM_write_request !== 1'b1 || oWM_write_address !== 32'h002F_FFFF) $display("FAIL wrap_addr: got req %0b addr %h want req 1 addr 002fffff", oWM_write_request, oWM_write_address); else n_pass++;
        n_total++; if (oWM_write_data !== dbase[3]) $display("FAIL wrap_data: got %h want %h", oWM_write_data, dbase[3]); else n_pass++;
        drive_cycle(); settle();
        drive_cycle(); settle();
    endtask

    task automatic test_reset_mid_burst();
        model_reset();
        drive_cycle(); iReq_write = 4'b0001; settle();
        drive_cycle(); settle();
        drive_cycle(); iReset_n = 1'b0; settle();
        n_total++; if (oWM_write_request !== 1'b1) $display("FAIL rstmid_pre: got %0b want 1", oWM_write_request); else n_pass++;
        drive_cycle(); settle();
        n_total++; if (oWM_write_request !== 1'b0 || oWM_write_address !== 32'd0 || oWM_write_data !== 32'd0) $display("FAIL rstmid_out: got req %0b addr %h data %h want all 0", oWM_write_request, oWM_write_address, oWM_write_data); else n_pass++;
        n_total++; if (oReq_wait !== 4'hF || oGrant_idx !== 2'd0 || oWM_finish !== 1'b0) $display("FAIL rstmid_state: got wait %b grant %0d finish %0b want 1111 0 0", oReq_wait, oGrant_idx, oWM_finish); else n_pass++;
        iReset_n = 1'b1; iReq_write = '0;
        drive_cycle(); settle();
    endtask

    initial begin
        test_reset();
        test_single_req2();
        test_rotation();
        test_backpressure();
        test_drop();
        test_finish();
        test_wrap();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
